// File: rtl/shift_sequencer_pkg.sv
// Shared model-computer definitions: sequencer state encoding, shifter select
// codes in {F,FL,FR} order, and the default datapath widths.
package shift_sequencer_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    typedef logic [2:0] sh_sel_t;

    localparam sh_sel_t SEL_NONE  = 3'b000;
    localparam sh_sel_t SEL_PASS  = 3'b100;
    localparam sh_sel_t SEL_LEFT  = 3'b010;
    localparam sh_sel_t SEL_RIGHT = 3'b001;

    // Select lines are a pure decode of the registered state, so at most one
    // of them can ever be asserted and none outside PASS/SHIFT.
    function automatic sh_sel_t sel_decode(input seq_state_t st, input logic dir_right);
        sh_sel_t sel;
        sel = SEL_NONE;
        case (st)
            ST_PASS:  sel = SEL_PASS;
            ST_SHIFT: sel = dir_right ? SEL_RIGHT : SEL_LEFT;
            default:  sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Controller-side request/result handshake of the rotate sequencer.
interface shift_sequencer_if
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic             cf_out;

    modport master (
        output start, dir, count, din,
        input  busy, done, dout, cf_out
    );

    modport slave (
        input  start, dir, count, din,
        output busy, done, dout, cf_out
    );

endinterface

// File: rtl/shift_sequencer.sv
// Rotate-by-N sequencer: loops an external 8-bit shift register stage N times,
// feeding each shifter result back as the next operand.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    shift_sequencer_if.slave    bus,
    output logic [WIDTH-1:0]    sh_a,
    output logic                sh_f_bus,
    output logic                sh_fl_bus,
    output logic                sh_fr_bus,
    input  logic [WIDTH-1:0]    sh_w,
    input  logic                sh_cf
);

    seq_state_t       state_q, state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] dout_q;
    logic             cf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             cap_en;
    logic             upd_en;
    sh_sel_t          sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            dout_q  <= '0;
            cf_q    <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (cap_en) begin
                data_q <= bus.din;
                cnt_q  <= bus.count;
                dir_q  <= bus.dir;
            end
            // Shifter result is both the visible result and the next operand.
            if (upd_en) begin
                data_q <= sh_w;
                dout_q <= sh_w;
                cf_q   <= sh_cf;
                if (state_q == ST_SHIFT) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        cap_en    = 1'b0;
        upd_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cap_en    = 1'b1;
                    state_nxt = (bus.count == '0) ? ST_PASS : ST_SHIFT;
                end
            end
            ST_PASS: begin
                upd_en    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_SHIFT: begin
                upd_en = 1'b1;
                // Exit at one remaining step so the counter never wraps.
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sel = sel_decode(state_q, dir_q);
    assign {sh_f_bus, sh_fl_bus, sh_fr_bus} = sel;
    assign sh_a = data_q;

    assign bus.busy   = (state_q == ST_PASS) || (state_q == ST_SHIFT);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.dout   = dout_q;
    assign bus.cf_out = cf_q;

endmodule
